// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader.
// Checksum support is selected at build time with PROG_LOADER_CKSUM_EN.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_DONE
  } state_t;

  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
  localparam int unsigned WORD_W         = 32;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
// The slave modport is the loader; the master modport is the host/memory side.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 5
);
  logic [7:0]                        rx_data;
  logic                              rx_valid;
  logic                              rx_ready;
  logic                              pm_we;
  logic [ADDR_W-1:0]                 pm_addr;
  logic [prog_loader_pkg::WORD_W-1:0] pm_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, pm_we, pm_addr, pm_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, pm_we, pm_addr, pm_wdata
  );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// Collects four stream bytes little-endian into one instruction word and
// presents it with a one-cycle word_valid; the word is held until the next one.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_last_byte,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word
);

  logic [1:0]        r_idx;
  logic [WORD_W-9:0] r_shift;
  logic [WORD_W-1:0] r_word;
  logic              r_word_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx        <= '0;
      r_shift      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clr) begin
        r_idx <= '0;
      end else if (i_byte_valid) begin
        r_idx <= r_idx + 1'b1;
        // Bytes enter at the top so b0 ends up in the least significant lane.
        if (r_idx == 2'd3) begin
          r_word       <= {i_byte, r_shift};
          r_word_valid <= 1'b1;
        end else begin
          r_shift <= {i_byte, r_shift[WORD_W-9:8]};
        end
      end
    end
  end

  assign o_last_byte  = (r_idx == 2'd3);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing sequential instruction words into program
// memory. Define PROG_LOADER_CKSUM_EN to require a trailing checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter logic [7:0]  HEADER = HEADER_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  prog_loader_if.slave      bus,
  input  logic              reload,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  state_t            r_state, w_next;
  logic              r_rx_ready, w_ready_nxt;
  logic              r_load_done, r_load_err;
  logic [ADDR_W:0]   r_words, r_len, w_words_inc;
  logic [ADDR_W-1:0] r_pm_addr;
  logic              w_hs, w_hdr, w_len_bad;
  logic              w_last_byte, w_word_valid;
  logic [WORD_W-1:0] w_word;

`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0] r_sum, w_sum_chk;
  assign w_sum_chk = r_sum + bus.rx_data;
`endif

  assign w_hs        = bus.rx_valid && r_rx_ready;
  assign w_hdr       = (bus.rx_data == HEADER);
  assign w_len_bad   = (bus.rx_data == 8'd0) || (32'(bus.rx_data) > DEPTH);
  assign w_words_inc = r_words + 1'b1;

  word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (r_state == ST_IDLE),
    .i_byte_valid (w_hs && (r_state == ST_DATA)),
    .i_byte       (bus.rx_data),
    .o_last_byte  (w_last_byte),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // After the final data byte, ready drops for one cycle while the last word
  // is written, so nothing is accepted before leaving DATA.
  always_comb begin
    w_next      = r_state;
    w_ready_nxt = 1'b1;
    case (r_state)
      ST_IDLE: if (w_hs && w_hdr) w_next = ST_LEN;
      ST_LEN:  if (w_hs) w_next = w_len_bad ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (r_words == r_len) begin
`ifdef PROG_LOADER_CKSUM_EN
          w_next = ST_CHK;
`else
          w_next = ST_DONE;
`endif
        end else if (w_hs && w_last_byte && (w_words_inc == r_len)) begin
          w_ready_nxt = 1'b0;
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      ST_CHK:  if (w_hs) w_next = (w_sum_chk == 8'h00) ? ST_DONE : ST_IDLE;
`endif
      ST_DONE: if (reload) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (w_next == ST_DONE) w_ready_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_rx_ready  <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_words     <= '0;
      r_len       <= '0;
      r_pm_addr   <= '0;
`ifdef PROG_LOADER_CKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_state    <= w_next;
      r_rx_ready <= w_ready_nxt;
      if ((w_next == ST_DONE) && (r_state != ST_DONE)) r_load_done <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_hs && w_hdr) begin
          r_load_err <= 1'b0;
          r_words    <= '0;
`ifdef PROG_LOADER_CKSUM_EN
          r_sum      <= '0;
`endif
        end
        ST_LEN: if (w_hs) begin
          if (w_len_bad) r_load_err <= 1'b1;
          else           r_len      <= bus.rx_data[ADDR_W:0];
        end
        ST_DATA: if (w_hs) begin
`ifdef PROG_LOADER_CKSUM_EN
          r_sum <= r_sum + bus.rx_data;
`endif
          if (w_last_byte) begin
            r_words   <= w_words_inc;
            r_pm_addr <= r_words[ADDR_W-1:0];
          end
        end
`ifdef PROG_LOADER_CKSUM_EN
        ST_CHK: if (w_hs && (w_sum_chk != 8'h00)) r_load_err <= 1'b1;
`endif
        ST_DONE: if (reload) r_load_done <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.rx_ready  = r_rx_ready;
  assign bus.pm_we     = w_word_valid;
  assign bus.pm_addr   = r_pm_addr;
  assign bus.pm_wdata  = w_word;
  assign load_done     = r_load_done;
  assign load_err      = r_load_err;
  assign words_loaded  = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random and directed frames compared
// against a frame-level reference parser of the byte stream.
module tb_prog_loader;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam logic [7:0]  HDR    = 8'hA5;
`ifdef PROG_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic reload = 1'b0;
  logic load_done, load_err;
  logic [ADDR_W:0] words_loaded;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HEADER(HDR)) dut (
    .clk(clk), .rst(rst), .bus(bus), .reload(reload),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Observation, sampled on the falling edge.
  int          cyc = 0;
  logic        prev_done = 1'b0;
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          hs_cyc_q[$];
  int          done_cyc = -1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.pm_we) begin
      wr_addr_q.push_back(int'(bus.pm_addr));
      wr_data_q.push_back(bus.pm_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.rx_valid && bus.rx_ready) hs_cyc_q.push_back(cyc);
    if (load_done && !prev_done) done_cyc = cyc;
    prev_done = load_done;
  end

  // Reference model state.
  logic [7:0]  stim[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  bit          m_done;
  bit          m_err = 1'b0;
  int          m_words = 0;

  task automatic model_run();
    int i = 0;
    int n, sum;
    logic [7:0] b;
    exp_addr.delete(); exp_data.delete();
    m_done = 1'b0;
    while (i < stim.size() && !m_done) begin
      b = stim[i]; i++;
      if (b != HDR) continue;
      m_err = 1'b0; m_words = 0;
      n = int'(stim[i]); i++;
      if (n == 0 || n > DEPTH) begin m_err = 1'b1; continue; end
      sum = 0;
      for (int k = 0; k < n; k++) begin
        exp_addr.push_back(k);
        exp_data.push_back({stim[i+3], stim[i+2], stim[i+1], stim[i]});
        sum += int'(stim[i]) + int'(stim[i+1]) + int'(stim[i+2]) + int'(stim[i+3]);
        m_words++; i += 4;
      end
      if (CK) begin
        if (((sum + int'(stim[i])) % 256) == 0) m_done = 1'b1; else m_err = 1'b1;
        i++;
      end else begin
        m_done = 1'b1;
      end
    end
  endtask

  task automatic add_frame(input int n, input bit good);
    int sum = 0;
    logic [7:0] b;
    stim.push_back(HDR);
    stim.push_back(8'(n));
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom); sum += int'(b); stim.push_back(b);
    end
    if (CK) stim.push_back(8'(256 - (sum % 256)) + (good ? 8'd0 : 8'd1));
  endtask

  task automatic add_good_fixed();
    logic [7:0] g[10] = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    foreach (g[i]) stim.push_back(g[i]);
    if (CK) stim.push_back(8'hFA);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    bus.rx_data = b; bus.rx_valid = 1'b1;
    @(negedge clk);
    while (!bus.rx_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.rx_ready) begin
      vectors++; miscompares++;
      $display("FAIL handshake_timeout: rx_ready=%0b after %0d cycles, required 1", bus.rx_ready, n);
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0; bus.rx_data = HDR;
  endtask

  task automatic send_stream(input int mode);
    foreach (stim[i]) begin
      int gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      send_byte(stim[i]);
    end
  endtask

  task automatic settle();
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic clear_obs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); hs_cyc_q.delete();
    done_cyc = -1;
  endtask

  task automatic do_reload();
    reload = 1'b1; @(posedge clk); #1; reload = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = HDR;
    repeat (3) begin @(posedge clk); #1; end
    vectors++; if ({bus.rx_ready, bus.pm_we, load_done, load_err} !== 4'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 0000", {bus.rx_ready, bus.pm_we, load_done, load_err}); end
    vectors++; if (bus.pm_addr !== '0 || bus.pm_wdata !== '0 || words_loaded !== '0) begin
      miscompares++; $display("FAIL reset_bus: addr %0h data %0h words %0d expected 0", bus.pm_addr, bus.pm_wdata, words_loaded); end
    rst = 1'b1; m_err = 1'b0; m_words = 0; clear_obs();
    @(posedge clk); #1;
    vectors++; if (bus.rx_ready !== 1'b1 || bus.pm_we !== 1'b0) begin
      miscompares++; $display("FAIL release: rx_ready %b pm_we %b expected 1 0", bus.rx_ready, bus.pm_we); end
  endtask

  task automatic test_good_frame();
    logic [31:0] ew[2] = '{32'h00500013, 32'h00100093};
    clear_obs(); stim.delete(); add_good_fixed();
    send_stream(0); settle();
    vectors++; if (wr_addr_q.size() != 2) begin
      miscompares++; $display("FAIL good_wcount: got %0d expected 2", wr_addr_q.size()); end
    for (int k = 0; k < 2; k++) begin
      vectors++; if (wr_addr_q[k] !== k || wr_data_q[k] !== ew[k]) begin
        miscompares++; $display("FAIL good_write%0d: got %0d/%h expected %0d/%h", k, wr_addr_q[k], wr_data_q[k], k, ew[k]); end
    end
    vectors++; if ({load_done, load_err, bus.rx_ready} !== 3'b100 || words_loaded !== 6'd2) begin
      miscompares++; $display("FAIL good_status: done/err/ready %b words %0d expected 100 2", {load_done, load_err, bus.rx_ready}, words_loaded); end
    vectors++; if (wr_cyc_q[0] !== hs_cyc_q[5] + 1) begin
      miscompares++; $display("FAIL good_we_latency: got cycle %0d expected %0d", wr_cyc_q[0], hs_cyc_q[5] + 1); end
    vectors++; if (done_cyc !== (CK ? hs_cyc_q[10] + 1 : hs_cyc_q[9] + 2)) begin
      miscompares++; $display("FAIL good_done_latency: got cycle %0d expected %0d", done_cyc, CK ? hs_cyc_q[10] + 1 : hs_cyc_q[9] + 2); end
    do_reload();
  endtask

`ifdef PROG_LOADER_CKSUM_EN
  task automatic test_bad_cksum();
    clear_obs(); stim.delete(); add_good_fixed();
    stim[stim.size() - 1] = 8'hFB;
    send_stream(0); settle();
    vectors++; if (wr_addr_q.size() != 2) begin
      miscompares++; $display("FAIL badck_wcount: got %0d expected 2", wr_addr_q.size()); end
    vectors++; if ({load_done, load_err, bus.rx_ready} !== 3'b011) begin
      miscompares++; $display("FAIL badck_status: done/err/ready %b expected 011", {load_done, load_err, bus.rx_ready}); end
    m_err = 1'b1;
  endtask
`endif

  task automatic test_bad_len();
    logic [7:0] lens[2] = '{8'h00, 8'h21};
    foreach (lens[j]) begin
      clear_obs(); stim.delete();
      stim.push_back(HDR); stim.push_back(lens[j]);
      model_run(); send_stream(j); settle();
      vectors++; if (load_err !== m_err || load_done !== 1'b0 || bus.rx_ready !== 1'b1) begin
        miscompares++; $display("FAIL badlen%0d_status: err/done/ready %b%b%b expected %b01", j, load_err, load_done, bus.rx_ready, m_err); end
      vectors++; if (wr_addr_q.size() != 0 || words_loaded !== 6'd0) begin
        miscompares++; $display("FAIL badlen%0d_writes: got %0d writes, words %0d expected 0 0", j, wr_addr_q.size(), words_loaded); end
    end
    clear_obs(); stim.delete(); add_good_fixed(); model_run();
    send_byte(stim[0]);
    vectors++; if (load_err !== 1'b0) begin
      miscompares++; $display("FAIL badlen_err_clear: got %b expected 0", load_err); end
    void'(stim.pop_front());
    send_stream(0); settle();
    vectors++; if (wr_addr_q.size() != exp_addr.size() || load_done !== m_done) begin
      miscompares++; $display("FAIL badlen_recover: writes %0d done %b expected %0d %b", wr_addr_q.size(), load_done, exp_addr.size(), m_done); end
    do_reload();
  endtask

  task automatic test_noise_stall();
    clear_obs(); stim.delete();
    stim.push_back(8'h00); stim.push_back(8'hFF);
    add_good_fixed(); model_run();
    send_stream(1); settle();
    vectors++; if (wr_addr_q.size() != exp_addr.size()) begin
      miscompares++; $display("FAIL noise_wcount: got %0d expected %0d", wr_addr_q.size(), exp_addr.size()); end
    foreach (exp_addr[k]) begin
      vectors++; if (wr_addr_q[k] !== exp_addr[k] || wr_data_q[k] !== exp_data[k]) begin
        miscompares++; $display("FAIL noise_write%0d: got %0d/%h expected %0d/%h", k, wr_addr_q[k], wr_data_q[k], exp_addr[k], exp_data[k]); end
    end
    vectors++; if (load_done !== m_done || words_loaded !== 6'(m_words)) begin
      miscompares++; $display("FAIL noise_status: done %b words %0d expected %b %0d", load_done, words_loaded, m_done, m_words); end
    do_reload();
  endtask

  task automatic test_reload_ignored();
    clear_obs(); stim.delete(); add_frame(1, 1'b1); model_run();
    do_reload();
    vectors++; if (bus.rx_ready !== 1'b1 || load_done !== 1'b0) begin
      miscompares++; $display("FAIL reload_idle: ready %b done %b expected 1 0", bus.rx_ready, load_done); end
    for (int i = 0; i < 4; i++) send_byte(stim[i]);
    do_reload();
    for (int i = 4; i < stim.size(); i++) send_byte(stim[i]);
    settle();
    vectors++; if (wr_addr_q.size() != 1 || wr_data_q[0] !== exp_data[0] || load_done !== m_done) begin
      miscompares++; $display("FAIL reload_data: writes %0d data %h done %b expected 1 %h %b", wr_addr_q.size(), wr_data_q[0], load_done, exp_data[0], m_done); end
    if (load_done) do_reload();
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int it = 0; it < 6; it++) begin
      clear_obs(); stim.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom); if (b == HDR) b = 8'h00; stim.push_back(b);
      end
      add_frame((it == 0) ? int'(DEPTH) : int'($urandom_range(1, 8)), ($urandom_range(0, 3) != 0));
      model_run(); send_stream(2); settle();
      vectors++; if (wr_addr_q.size() != exp_addr.size()) begin
        miscompares++; $display("FAIL rnd%0d_wcount: got %0d expected %0d", it, wr_addr_q.size(), exp_addr.size()); end
      foreach (exp_addr[k]) begin
        vectors++; if (wr_addr_q[k] !== exp_addr[k] || wr_data_q[k] !== exp_data[k]) begin
          miscompares++; $display("FAIL rnd%0d_write%0d: got %0d/%h expected %0d/%h", it, k, wr_addr_q[k], wr_data_q[k], exp_addr[k], exp_data[k]); end
      end
      vectors++; if (load_done !== m_done || load_err !== m_err || words_loaded !== 6'(m_words)) begin
        miscompares++; $display("FAIL rnd%0d_status: done %b err %b words %0d expected %b %b %0d", it, load_done, load_err, words_loaded, m_done, m_err, m_words); end
      if (load_done) do_reload();
    end
  endtask

  task automatic test_mid_reset();
    clear_obs(); stim.delete();
    add_good_fixed();
    for (int i = 0; i < 7; i++) send_byte(stim[i]);
    rst = 1'b0; @(posedge clk); #1;
    vectors++; if ({bus.rx_ready, bus.pm_we, load_done, load_err} !== 4'b0 || words_loaded !== '0 || bus.pm_addr !== '0) begin
      miscompares++; $display("FAIL midrst_outputs: flags %b words %0d addr %0d expected 0", {bus.rx_ready, bus.pm_we, load_done, load_err}, words_loaded, bus.pm_addr); end
    rst = 1'b1; m_err = 1'b0; m_words = 0;
    @(posedge clk); #1;
    clear_obs(); model_run(); send_stream(0); settle();
    vectors++; if (wr_addr_q.size() != exp_addr.size()) begin
      miscompares++; $display("FAIL midrst_wcount: got %0d expected %0d", wr_addr_q.size(), exp_addr.size()); end
    foreach (exp_addr[k]) begin
      vectors++; if (wr_addr_q[k] !== exp_addr[k] || wr_data_q[k] !== exp_data[k]) begin
        miscompares++; $display("FAIL midrst_write%0d: got %0d/%h expected %0d/%h", k, wr_addr_q[k], wr_data_q[k], exp_addr[k], exp_data[k]); end
    end
    vectors++; if (load_done !== 1'b1) begin
      miscompares++; $display("FAIL midrst_done: got %b expected 1", load_done); end
    reload = 1'b1; @(posedge clk); #1; reload = 1'b0;
    vectors++; if (load_done !== 1'b0 || bus.rx_ready !== 1'b1) begin
      miscompares++; $display("FAIL midrst_reload: done %b ready %b expected 0 1", load_done, bus.rx_ready); end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = HDR;
    test_reset();
    test_good_frame();
`ifdef PROG_LOADER_CKSUM_EN
    test_bad_cksum();
`endif
    test_bad_len();
    test_noise_stall();
    test_reload_ignored();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
